// File: rtl/eink_pkg.sv
// Shared types and constants for the e-ink update scheduler: modes, request record, FSM states.
package eink_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 10;

    localparam logic [MODE_W-1:0] MODE_CLEAR = 2'd0;
    localparam logic [MODE_W-1:0] MODE_DRAW  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_TEST  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_RSVD  = 2'd3;

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic              clip;
        logic [X_W-1:0]    x1;
        logic [X_W-1:0]    x2;
        logic [Y_W-1:0]    y1;
        logic [Y_W-1:0]    y2;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // Anti-ghosting full-screen draw inserted by the scheduler itself
    localparam req_t FULL_JOB = '{mode: MODE_DRAW, clip: 1'b0, x1: '0, x2: '0, y1: '0, y2: '0};

    // Clipped rectangles are stored with ascending bounds
    function automatic req_t req_normalize(input req_t r);
        req_t n;
        n = r;
        if (r.clip) begin
            if (r.x1 > r.x2) begin
                n.x1 = r.x2;
                n.x2 = r.x1;
            end
            if (r.y1 > r.y2) begin
                n.y1 = r.y2;
                n.y2 = r.y1;
            end
        end
        return n;
    endfunction

    function automatic req_t req_bbox(input req_t a, input req_t b);
        req_t n;
        n    = a;
        n.x1 = (b.x1 < a.x1) ? b.x1 : a.x1;
        n.x2 = (b.x2 > a.x2) ? b.x2 : a.x2;
        n.y1 = (b.y1 < a.y1) ? b.y1 : a.y1;
        n.y2 = (b.y2 > a.y2) ? b.y2 : a.y2;
        return n;
    endfunction

endpackage

// File: rtl/eink_req_fifo.sv
// Request FIFO with push/pop/level plus a tail read/rewrite port for in-place merging.
module eink_req_fifo
    import eink_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  req_t                   push_data,
    input  logic                   pop,
    output req_t                   head,
    input  logic                   tail_wr,
    input  req_t                   tail_data,
    output req_t                   tail,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    req_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  tail_idx;

    assign tail_idx = wr_ptr - AW'(1);
    assign head     = mem[rd_ptr];
    assign tail     = mem[tail_idx];
    assign empty    = (level == LW'(0));
    assign full     = (level == LW'(DEPTH));

    // Storage; push and tail rewrite are never requested together
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end else if (tail_wr) begin
            mem[tail_idx] <= tail_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/eink_update_scheduler.sv
// Queues host update requests and issues them to the panel controller, inserting periodic full draws.
// Optional EINK_SCHED_MERGE_EN: merge a clipped DRAW into a clipped-DRAW tail as a bounding box.
module eink_update_scheduler
    import eink_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned FULL_EVERY    = 8,
    parameter int unsigned START_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [MODE_W-1:0]      host_mode,
    input  logic                   host_clip,
    input  logic [X_W-1:0]         host_x1,
    input  logic [X_W-1:0]         host_x2,
    input  logic [Y_W-1:0]         host_y1,
    input  logic [Y_W-1:0]         host_y2,
    output logic [MODE_W-1:0]      pnl_mode,
    output logic                   pnl_clip,
    output logic [X_W-1:0]         pnl_x1,
    output logic [X_W-1:0]         pnl_x2,
    output logic [Y_W-1:0]         pnl_y1,
    output logic [Y_W-1:0]         pnl_y2,
    output logic                   pnl_start,
    input  logic                   pnl_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err_timeout,
    output logic                   err_mode
);

    localparam int unsigned LW     = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_W  = (FULL_EVERY == 0) ? 1 : $clog2(FULL_EVERY + 1);
    localparam int unsigned TMO_W  = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(FULL_EVERY);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

    state_t            state_q, state_d;
    req_t              job_q, job_d;
    logic              start_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  part_q, part_d;
    logic              err_tmo_d;
    logic              err_mode_d;

    req_t              host_req_c, norm_c, fifo_head, fifo_tail, tail_data_c;
    logic              fifo_empty, fifo_full;
    logic              accept_c, rsvd_c, merge_c, push_c, pop_c, tail_wr_c, full_due_c;

    assign host_req_c = '{mode: host_mode, clip: host_clip, x1: host_x1, x2: host_x2,
                          y1: host_y1, y2: host_y2};
    assign norm_c     = req_normalize(host_req_c);
    assign rsvd_c     = (host_mode == MODE_RSVD);

`ifdef EINK_SCHED_MERGE_EN
    // Merge only into a clipped-DRAW tail that is not leaving the FIFO this cycle
    assign merge_c     = (host_mode == MODE_DRAW) && host_clip && !fifo_empty
                         && (fifo_tail.mode == MODE_DRAW) && fifo_tail.clip
                         && !(pop_c && (level == LW'(1)));
    assign tail_data_c = req_bbox(fifo_tail, norm_c);
`else
    assign merge_c     = 1'b0;
    assign tail_data_c = fifo_tail;
`endif

    assign host_ready = !fifo_full || merge_c;
    assign accept_c   = host_valid && host_ready;
    assign push_c     = accept_c && !rsvd_c && !merge_c;
    assign tail_wr_c  = accept_c && merge_c;
    assign err_mode_d = accept_c && rsvd_c;
    assign full_due_c = (FULL_EVERY != 0) && (part_q >= FULL_LIM);

    eink_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (norm_c),
        .pop       (pop_c),
        .head      (fifo_head),
        .tail_wr   (tail_wr_c),
        .tail_data (tail_data_c),
        .tail      (fifo_tail),
        .level     (level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign pnl_mode = job_q.mode;
    assign pnl_clip = job_q.clip;
    assign pnl_x1   = job_q.x1;
    assign pnl_x2   = job_q.x2;
    assign pnl_y1   = job_q.y1;
    assign pnl_y2   = job_q.y2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            job_q       <= '0;
            pnl_start   <= 1'b0;
            tmo_q       <= '0;
            part_q      <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_mode    <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            pnl_start   <= start_d;
            tmo_q       <= tmo_d;
            part_q      <= part_d;
            busy        <= (state_d != ST_IDLE);
            err_timeout <= err_tmo_d;
            err_mode    <= err_mode_d;
        end
    end

    // Job selection, start handshake and partial-draw bookkeeping
    always_comb begin
        state_d   = state_q;
        job_d     = job_q;
        start_d   = pnl_start;
        tmo_d     = tmo_q;
        part_d    = part_q;
        err_tmo_d = 1'b0;
        pop_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pnl_ready && (full_due_c || !fifo_empty)) begin
                    job_d   = full_due_c ? FULL_JOB : fifo_head;
                    pop_c   = !full_due_c;
                    start_d = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!pnl_ready) begin
                    start_d = 1'b0;
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    start_d   = 1'b0;
                    err_tmo_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (pnl_ready) begin
                    state_d = ST_IDLE;
                    if ((job_q.mode == MODE_DRAW) && job_q.clip) begin
                        if (part_q < FULL_LIM) part_d = part_q + CNT_W'(1);
                    end else if ((job_q.mode == MODE_DRAW) || (job_q.mode == MODE_CLEAR)) begin
                        part_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eink_update_scheduler.sv
// Self-checking bench for eink_update_scheduler: directed steps plus random request batches vs a queue model.
module tb_eink_update_scheduler;
    import eink_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int          FE    = 2;
    localparam int unsigned TMO   = 1024;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              host_valid = 1'b0;
    logic              host_ready;
    logic [MODE_W-1:0] host_mode  = '0;
    logic              host_clip  = 1'b0;
    logic [X_W-1:0]    host_x1    = '0;
    logic [X_W-1:0]    host_x2    = '0;
    logic [Y_W-1:0]    host_y1    = '0;
    logic [Y_W-1:0]    host_y2    = '0;
    logic [MODE_W-1:0] pnl_mode;
    logic              pnl_clip;
    logic [X_W-1:0]    pnl_x1, pnl_x2;
    logic [Y_W-1:0]    pnl_y1, pnl_y2;
    logic              pnl_start;
    logic              pnl_ready  = 1'b1;
    logic              busy;
    logic [LW-1:0]     level;
    logic              err_timeout, err_mode;

    int   n_checks = 0;
    int   n_fail   = 0;
    req_t mq[$];
    int   mcnt     = 0;

    always #5 clk = ~clk;

    eink_update_scheduler #(.DEPTH(DEPTH), .FULL_EVERY(FE), .START_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_valid(host_valid), .host_ready(host_ready), .host_mode(host_mode),
        .host_clip(host_clip), .host_x1(host_x1), .host_x2(host_x2),
        .host_y1(host_y1), .host_y2(host_y2),
        .pnl_mode(pnl_mode), .pnl_clip(pnl_clip), .pnl_x1(pnl_x1), .pnl_x2(pnl_x2),
        .pnl_y1(pnl_y1), .pnl_y2(pnl_y2), .pnl_start(pnl_start), .pnl_ready(pnl_ready),
        .busy(busy), .level(level), .err_timeout(err_timeout), .err_mode(err_mode)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic req_t mk(input logic [1:0] m, input logic c,
                                input int x1, input int x2, input int y1, input int y2);
        req_t r;
        r.mode = m;
        r.clip = c;
        r.x1   = X_W'(x1);
        r.x2   = X_W'(x2);
        r.y1   = Y_W'(y1);
        r.y2   = Y_W'(y2);
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    endfunction

    function automatic req_t pnl_now();
        return '{mode: pnl_mode, clip: pnl_clip, x1: pnl_x1, x2: pnl_x2, y1: pnl_y1, y2: pnl_y2};
    endfunction

    // Reference model: a queue of normalized requests plus a partial-draw count
    function automatic void model_push(input req_t r);
        req_t n;
        if (r.mode == MODE_RSVD) return;
        n = r;
        if (r.clip && r.x1 > r.x2) begin n.x1 = r.x2; n.x2 = r.x1; end
        if (r.clip && r.y1 > r.y2) begin n.y1 = r.y2; n.y2 = r.y1; end
`ifdef EINK_SCHED_MERGE_EN
        // Bench only pushes into a non-empty queue while no pop can happen
        if (mq.size() > 0 && n.mode == MODE_DRAW && n.clip
            && mq[$].mode == MODE_DRAW && mq[$].clip) begin
            if (n.x1 < mq[$].x1) mq[$].x1 = n.x1;
            if (n.x2 > mq[$].x2) mq[$].x2 = n.x2;
            if (n.y1 < mq[$].y1) mq[$].y1 = n.y1;
            if (n.y2 > mq[$].y2) mq[$].y2 = n.y2;
            return;
        end
`endif
        mq.push_back(n);
    endfunction

    function automatic bit model_full_due();
        return (FE != 0) && (mcnt >= FE);
    endfunction

    function automatic bit model_pending();
        return (mq.size() > 0) || model_full_due();
    endfunction

    function automatic req_t model_next();
        if (model_full_due()) return mk(MODE_DRAW, 1'b0, 0, 0, 0, 0);
        if (mq.size() == 0) return '0;
        return mq.pop_front();
    endfunction

    function automatic void model_done(input req_t e);
        if (e.mode == MODE_DRAW && e.clip) begin
            if (mcnt < FE) mcnt++;
        end else if (e.mode == MODE_DRAW || e.mode == MODE_CLEAR) begin
            mcnt = 0;
        end
    endfunction

    task automatic drive(input req_t r);
        host_mode = r.mode;
        host_clip = r.clip;
        host_x1   = r.x1;
        host_x2   = r.x2;
        host_y1   = r.y1;
        host_y2   = r.y2;
    endtask

    task automatic push(input req_t r);
        int n = 0;
        drive(r);
        host_valid = 1'b1;
        while (host_ready !== 1'b1 && n < 200) begin tick(); n++; end
        chk("host_ready_wait", 64'(host_ready), 64'(1));
        tick();
        host_valid = 1'b0;
        model_push(r);
        chk("err_mode_pulse", 64'(err_mode), 64'(r.mode == MODE_RSVD));
    endtask

    task automatic wait_issue(output req_t e);
        int n = 0;
        while (pnl_start !== 1'b1 && n < 64) begin tick(); n++; end
        chk("issue_seen", 64'(pnl_start), 64'(1));
        e = model_next();
        chk("issue_job", 64'(pnl_now()), 64'(e));
        chk("issue_busy", 64'(busy), 64'(1));
    endtask

    task automatic finish_job(input req_t e, input int hold);
        repeat (hold) tick();
        chk("start_held", 64'(pnl_start), 64'(1));
        pnl_ready = 1'b0;
        tick();
        chk("start_fall", 64'(pnl_start), 64'(0));
        repeat ($urandom_range(0, 3)) tick();
        chk("job_held", 64'(pnl_now()), 64'(e));
        chk("wait_busy", 64'(busy), 64'(1));
        pnl_ready = 1'b1;
        tick();
        model_done(e);
    endtask

    task automatic serve_all();
        req_t e;
        int   guard = 0;
        while (model_pending() && guard < 20) begin
            wait_issue(e);
            finish_job(e, int'($urandom_range(0, 5)));
            guard++;
        end
    endtask

    initial begin
        req_t e;
        logic [3:0] seq;
        int nseq;

        // Reset state
        tick(); tick();
        chk("rst_start", 64'(pnl_start), 64'(0));
        chk("rst_pnl", 64'(pnl_now()), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_ready", 64'(host_ready), 64'(1));
        chk("rst_errs", 64'({err_timeout, err_mode}), 64'(0));
        rst_n = 1'b1;
        tick();

        // First-request latency and handshake
        push(mk(MODE_DRAW, 1'b1, 10, 20, 100, 200));
        chk("t1_no_start_at_e", 64'(pnl_start), 64'(0));
        tick();
        chk("t1_start_at_e1", 64'(pnl_start), 64'(1));
        wait_issue(e);
        chk("t1_rect", 64'(pnl_now()), 64'(mk(MODE_DRAW, 1'b1, 10, 20, 100, 200)));
        finish_job(e, 3);
        chk("t1_idle", 64'(busy), 64'(0));

        // FIFO fill and backpressure, then FIFO-order issue
        pnl_ready = 1'b0;
        push(mk(MODE_TEST, 1'b1, 1, 2, 3, 4));
        push(mk(MODE_CLEAR, 1'b0, 0, 0, 0, 0));
        push(mk(MODE_DRAW, 1'b0, 7, 8, 9, 10));
        push(mk(MODE_TEST, 1'b0, 11, 12, 13, 14));
        chk("t2_level_full", 64'(level), 64'(4));
        chk("t2_ready_low", 64'(host_ready), 64'(0));
        drive(mk(MODE_DRAW, 1'b0, 33, 44, 55, 66));
        host_valid = 1'b1;
        repeat (3) tick();
        chk("t2_no_accept", 64'(level), 64'(4));
        host_valid = 1'b0;
        pnl_ready = 1'b1;
        serve_all();
        push(mk(MODE_DRAW, 1'b0, 33, 44, 55, 66));
        serve_all();

        // Auto full-screen insertion after FE partial draws
        pnl_ready = 1'b0;
        push(mk(MODE_DRAW, 1'b1, 1, 9, 1, 9));
        push(mk(MODE_DRAW, 1'b1, 2, 8, 2, 8));
        push(mk(MODE_DRAW, 1'b1, 3, 7, 3, 7));
        pnl_ready = 1'b1;
        seq = '0;
        nseq = 0;
        while (model_pending() && nseq < 8) begin
            wait_issue(e);
            seq = {seq[2:0], e.clip};
            finish_job(e, 1);
            nseq++;
        end
`ifndef EINK_SCHED_MERGE_EN
        chk("t3_issue_count", 64'(nseq), 64'(4));
        chk("t3_clip_order", 64'(seq), 64'(4'b1101));
`endif

        // Start timeout, then the next queued job issues
        pnl_ready = 1'b0;
        push(mk(MODE_TEST, 1'b0, 5, 6, 7, 8));
        push(mk(MODE_CLEAR, 1'b0, 0, 0, 0, 0));
        pnl_ready = 1'b1;
        wait_issue(e);
        repeat (TMO - 1) tick();
        chk("t4_start_before_tmo", 64'(pnl_start), 64'(1));
        chk("t4_no_err_yet", 64'(err_timeout), 64'(0));
        tick();
        chk("t4_start_tmo_fall", 64'(pnl_start), 64'(0));
        chk("t4_err_timeout", 64'(err_timeout), 64'(1));
        tick();
        chk("t4_err_one_cycle", 64'(err_timeout), 64'(0));
        wait_issue(e);
        finish_job(e, 0);

        // Reserved mode drop and rectangle swap
        push(mk(MODE_RSVD, 1'b1, 1, 2, 3, 4));
        chk("t5_rsvd_level", 64'(level), 64'(0));
        tick();
        chk("t5_err_mode_off", 64'(err_mode), 64'(0));
        chk("t5_no_issue", 64'(pnl_start), 64'(0));
        push(mk(MODE_DRAW, 1'b1, 50, 5, 7, 3));
        wait_issue(e);
        chk("t5_swap_x", 64'({pnl_x1, pnl_x2}), 64'({8'd5, 8'd50}));
        chk("t5_swap_y", 64'({pnl_y1, pnl_y2}), 64'({10'd3, 10'd7}));
        finish_job(e, 2);
        serve_all();

        // Random batches queued while the panel is busy, then drained
        for (int round = 0; round < 4; round++) begin
            pnl_ready = 1'b0;
            for (int i = 0; i < int'($urandom_range(1, DEPTH)); i++) push(rand_req());
            chk("rnd_level", 64'(level), 64'(mq.size()));
            pnl_ready = 1'b1;
            serve_all();
            chk("rnd_idle", 64'(busy), 64'(0));
        end

`ifdef EINK_SCHED_MERGE_EN
        // Merge into the tail while a run is in progress
        push(mk(MODE_TEST, 1'b0, 0, 0, 0, 0));
        wait_issue(e);
        pnl_ready = 1'b0;
        tick();
        push(mk(MODE_DRAW, 1'b1, 10, 20, 100, 200));
        push(mk(MODE_DRAW, 1'b1, 5, 15, 150, 300));
        chk("t6_merge_level", 64'(level), 64'(1));
        pnl_ready = 1'b1;
        tick();
        model_done(e);
        wait_issue(e);
        chk("t6_merge_rect", 64'(pnl_now()), 64'(mk(MODE_DRAW, 1'b1, 5, 20, 100, 300)));
        finish_job(e, 1);
        serve_all();
`endif

        // Reset in the middle of a run with the controller still busy
        push(mk(MODE_DRAW, 1'b1, 40, 60, 10, 20));
        wait_issue(e);
        pnl_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t7_rst_start", 64'(pnl_start), 64'(0));
        chk("t7_rst_pnl", 64'(pnl_now()), 64'(0));
        chk("t7_rst_busy", 64'(busy), 64'(0));
        chk("t7_rst_level", 64'(level), 64'(0));
        chk("t7_rst_ready", 64'(host_ready), 64'(1));
        mq.delete();
        mcnt = 0;
        tick();
        rst_n = 1'b1;
        tick();
        push(mk(MODE_CLEAR, 1'b0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t7_hold_off", 64'(pnl_start), 64'(0));
        end
        pnl_ready = 1'b1;
        wait_issue(e);
        finish_job(e, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
